// File: rtl/mem_readout.sv
// mem_readout: reads out one of two memory pages on request and streams the
// words through a two-stage registered pipeline.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   en_proc                processing enable; low stalls address generation
//   start[1:0]             per-page request pulses (bit p -> page p)
//   number_in0/1           entry count of page 0 / page 1 (saturates at 2^ADDR_WIDTH)
//   rd_en, rd_addr         memory read strobe and {page, index} address
//   rd_data                memory data, valid the cycle after rd_en
//   data_out, valid        registered readout word and its qualifier
//   done[1:0]              one-cycle completion pulse per page
module mem_readout #(
  parameter int unsigned INPUT_SIZE = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_proc,
  input  logic [1:0]            start,
  input  logic [ADDR_WIDTH:0]   number_in0,
  input  logic [ADDR_WIDTH:0]   number_in1,
  output logic                  rd_en,
  output logic [ADDR_WIDTH:0]   rd_addr,
  input  logic [INPUT_SIZE-1:0] rd_data,
  output logic [INPUT_SIZE-1:0] data_out,
  output logic                  valid,
  output logic [1:0]            done
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic                  page_q, page_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         idx_q, idx_d;     // number of entries already issued
  logic                  drain_q, drain_d; // second DRAIN cycle marker
  logic                  rd_en_d;
  logic [CW-1:0]         rd_addr_d;
  logic [1:0]            done_d;
  logic                  pipe_q;           // read issued in the previous cycle

  logic [1:0]            req;
  logic                  sel_page;
  logic [CW-1:0]         sel_raw;
  logic [CW-1:0]         sel_cnt;

  // Request arbitration: page 0 wins; counts above page depth saturate.
  always_comb begin
    req      = pend_q | start;
    sel_page = ~req[0];
    sel_raw  = req[0] ? number_in0 : number_in1;
    sel_cnt  = (sel_raw > DEPTH) ? DEPTH : sel_raw;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | start;
    page_d    = page_q;
    n_d       = n_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    done_d    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          page_d           = sel_page;
          n_d              = sel_cnt;
          pend_d[sel_page] = 1'b0;
          idx_d            = '0;
          drain_d          = 1'b0;
          if (sel_cnt == '0) begin
            state_d = S_DRAIN;
          end else begin
            // The first read goes out in the cycle the FSM enters READ.
            state_d = S_READ;
            if (en_proc) begin
              rd_en_d   = 1'b1;
              rd_addr_d = {sel_page, {ADDR_WIDTH{1'b0}}};
              idx_d     = CW'(1);
            end
          end
        end
      end

      S_READ: begin
        if (idx_q == n_q) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else if (en_proc) begin
          rd_en_d   = 1'b1;
          rd_addr_d = {page_q, idx_q[ADDR_WIDTH-1:0]};
          idx_d     = idx_q + CW'(1);
        end
      end

      S_DRAIN: begin
        if (drain_q) begin
          state_d        = S_IDLE;
          done_d[page_q] = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, address generator and two-stage data pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 2'b00;
      page_q   <= 1'b0;
      n_q      <= '0;
      idx_q    <= '0;
      drain_q  <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      done     <= 2'b00;
      pipe_q   <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      page_q  <= page_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      done    <= done_d;
      pipe_q  <= rd_en;
      valid   <= pipe_q;
      if (pipe_q) begin
        data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_readout.sv
// tb_mem_readout: directed and randomized check of mem_readout against a
// transaction-level reference model (per-job issue count and countdown to done).
module tb_mem_readout;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = AW + 1;
  localparam int          DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          en_proc = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [CW-1:0] number_in0 = '0;
  logic [CW-1:0] number_in1 = '0;
  logic          rd_en;
  logic [CW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic [1:0]    done;

  mem_readout #(.INPUT_SIZE(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .en_proc(en_proc), .start(start),
    .number_in0(number_in0), .number_in1(number_in1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_out(data_out), .valid(valid), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:127];

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  bit [1:0]      m_pend;
  bit            m_active;
  int            m_pg, m_n, m_iss, m_cd;
  bit            e_rd_en, prev_en;
  logic [CW-1:0] e_rd_addr, prev_addr;
  bit            e_valid;
  logic [DW-1:0] e_data;
  bit [1:0]      e_done;

  // memory responder state: DUT read of the previous cycle
  bit            last_en;
  logic [CW-1:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 2'b00; m_active = 1'b0; m_pg = 0; m_n = 0; m_iss = 0; m_cd = 0;
    e_rd_en = 1'b0; e_rd_addr = '0; prev_en = 1'b0; prev_addr = '0;
    e_valid = 1'b0; e_data = '0; e_done = 2'b00;
  endfunction

  // Advance the model across one clock edge given the inputs sampled there.
  function automatic void model_step(input bit [1:0] s, input bit e, input int c0, input int c1);
    bit            nxt_en;
    logic [CW-1:0] nxt_addr;
    bit [1:0]      req;
    int            cnt;
    nxt_en   = 1'b0;
    nxt_addr = e_rd_addr;
    e_done   = 2'b00;
    req      = m_pend | s;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) begin
        e_done[m_pg] = 1'b1;
        m_active = 1'b0;
      end
    end else if (m_active) begin
      if (e) begin
        nxt_en = 1'b1;
        nxt_addr = CW'(m_pg * DEPTH + m_iss);
        m_iss++;
        if (m_iss == m_n) m_cd = 3;
      end
    end else if (req != 2'b00) begin
      m_pg = req[0] ? 0 : 1;
      req[m_pg] = 1'b0;
      cnt = (m_pg == 0) ? c0 : c1;
      m_n = (cnt > DEPTH) ? DEPTH : cnt;
      m_active = 1'b1;
      m_iss = 0;
      if (m_n == 0) begin
        m_cd = 2;
      end else if (e) begin
        nxt_en = 1'b1;
        nxt_addr = CW'(m_pg * DEPTH);
        m_iss = 1;
        if (m_n == 1) m_cd = 3;
      end
    end
    m_pend = req;
    // word read two cycles ago appears now
    e_valid = prev_en;
    if (prev_en) e_data = mem[prev_addr];
    prev_en   = e_rd_en;
    prev_addr = e_rd_addr;
    e_rd_en   = nxt_en;
    e_rd_addr = nxt_addr;
  endfunction

  // One clock cycle: drive inputs, step the model, compare after the edge.
  task automatic cyc(input bit [1:0] s, input bit e, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
    start = s; en_proc = e; number_in0 = c0; number_in1 = c1;
    model_step(s, e, int'(c0), int'(c1));
    @(posedge clk); #1;
    rd_data   = last_en ? mem[last_addr] : DW'($urandom);
    last_en   = rd_en;
    last_addr = rd_addr;
    chk("rd_en", 32'(rd_en), 32'(e_rd_en));
    chk("rd_addr", 32'(rd_addr), 32'(e_rd_addr));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b1, '0, '0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear immediately.
  task automatic do_reset(input int hold);
    reset_n = 1'b0; #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 2'b00; en_proc = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    last_en = 1'b0;
  endtask

  function automatic logic [CW-1:0] rand_cnt();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return CW'(0);
      1: return CW'(1);
      2: return CW'(64);
      3: return CW'(127);
      4: return CW'(65);
      default: return CW'($urandom_range(2, 8));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
    model_reset();
    last_en = 1'b0;
    #2;
    do_reset(3);

    // three-entry page 0 readout
    cyc(2'b01, 1'b1, CW'(3), CW'(0));
    idle(8);
    // both pages requested together, two entries each
    cyc(2'b11, 1'b1, CW'(2), CW'(2));
    idle(12);
    // empty page 1
    cyc(2'b10, 1'b1, CW'(0), CW'(0));
    idle(5);
    // two-cycle stall after the second read
    cyc(2'b01, 1'b1, CW'(5), CW'(0));
    cyc(2'b00, 1'b1, CW'(5), CW'(0));
    cyc(2'b00, 1'b0, CW'(5), CW'(0));
    cyc(2'b00, 1'b0, CW'(5), CW'(0));
    idle(10);
    // saturating count
    cyc(2'b01, 1'b1, CW'(127), CW'(0));
    idle(70);
    // repeated start on a pending page is absorbed
    cyc(2'b11, 1'b1, CW'(2), CW'(3));
    cyc(2'b10, 1'b1, CW'(2), CW'(3));
    idle(14);
    // reset during page 0 readout with page 1 pending
    cyc(2'b11, 1'b1, CW'(40), CW'(4));
    idle(5);
    do_reset(2);
    idle(3);
    cyc(2'b10, 1'b1, CW'(0), CW'(4));
    idle(10);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      bit [1:0] s;
      bit e;
      s = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) do_reset(1);
      cyc(s, e, rand_cnt(), rand_cnt());
    end
    idle(80);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
